colide_scan: RTL
================

// Module: colide_scan
// PURPOSE
//  Box-vs-obstacle collision engine for the moving-object VGA design. Single block for all four directions; replaces per-direction flat compare blocks.
//  Tests square box (xPos,yPos,tamanho) against a table of N_OBST rectangles, one obstacle per clock.
//  Returns colisao_min_x/max_x/min_y/max_y, used by the movement controller to block left/right/up/down keys.
// PARAMETERS
//  N_OBST  10  number of obstacle rectangles scanned (>=1)
//  X_W     10  width of x coordinates
//  Y_W     9   width of y coordinates
//  T_W     7   width of box size tamanho
// PORTS
//  VGA_clk        in   1    clock; all logic on posedge
//  reset          in   1    synchronous, active-high reset
//  start          in   1    pulse: latch xPos/yPos/tamanho, begin scan (IDLE only)
//  xPos           in   X_W  box left edge
//  yPos           in   Y_W  box top edge
//  tamanho        in   T_W  box side length
//  busy           out  1    high in SCAN and DONE
//  valid          out  1    one-cycle pulse: result flags updated
//  colisao_min_x  out  1    left edge strictly inside an obstacle's x-span, y-spans overlap
//  colisao_max_x  out  1    xPos+tamanho strictly inside x-span, y-spans overlap
//  colisao_min_y  out  1    yPos strictly inside y-span, x-spans overlap
//  colisao_max_y  out  1    yPos+tamanho strictly inside y-span, x-spans overlap
//  (COLIDE_OBST_WR_EN only) obst_we 1 in; obst_addr $clog2(N_OBST) in; obst_data in: one obstacle record
// BEHAVIOUR
//  - Reset: state IDLE, idx 0, accumulators 0, busy 0, valid 0, all colisao_* 0.
//  - FSM: IDLE -start-> SCAN (idx 0..N_OBST-1, one obstacle/cycle) -> DONE (1 cycle) -> IDLE.
//  - start sampled in IDLE only; start while busy ignored; inputs latched on accept, later input changes ignored.
//  - Latency: start accepted at cycle t -> valid high at t+N_OBST+1; busy high t+1..t+N_OBST+1.
//  - Overlap rules (per obstacle ini/fin): x-overlap = xPos+tamanho > ini_x && xPos < fin_x; y-overlap likewise.
//    Strict '>'/'<' everywhere: touching an edge is not a collision.
//  - Sums xPos+tamanho / yPos+tamanho computed at X_W+1 / Y_W+1 bits; no wrap-around.
//  - Flags OR-accumulated during SCAN; copied to colisao_* in DONE with valid; outputs hold until next DONE.
//  - N_OBST=1: SCAN lasts exactly one cycle; index width max(1,$clog2(N_OBST)).
//  - reset mid-scan: abort, no valid, outputs cleared to 0 next cycle.
// CONFIGURATION
//  COLIDE_OBST_WR_EN defined: obstacle table is a register array, reset-loaded from package defaults.
//    Write accepted when obst_we && state==IDLE && !start; write with start same cycle: start wins, write dropped.
//    Writes while busy dropped; obst_addr >= N_OBST dropped.
//  Undefined: table is a constant from the package; write ports absent.
// STRUCTURE
//  Package colide_pkg: obstacle_t struct {ini_x,fin_x,ini_y,fin_y}; widths; OBST_DEFAULT[10] maze table:
//    (105,350,100,110)(345,350,100,280)(105,280,170,180)(275,280,170,350)(345,590,270,280)
//    (275,510,340,350)(585,590,270,450)(505,510,340,390)(105,590,440,450)(105,510,380,390)
//  Sub-module colide_obst_cmp: combinational box-vs-one-obstacle, four direction flags; one instance, time-multiplexed.
// TESTING
//  1 Reset: hold reset 3 cycles -> busy=0, valid=0, all colisao_*=0.
//  2 xPos=200,yPos=95,tamanho=10, start at t -> valid at t+11; min_x=1, max_x=1, min_y=0, max_y=1.
//  3 xPos=105,yPos=95,tamanho=10 -> min_x=0 (edge is strict); max_x=1, max_y=1.
//  4 xPos=20,yPos=20,tamanho=10 (free space) -> valid at t+11, all flags 0; prior flags replaced.
//  5 start re-pulsed mid-scan and reset asserted at t+5 -> no valid, flags 0, next start completes normally.
//  6 (COLIDE_OBST_WR_EN) write addr 0=(0,100,0,100) idle; xPos=50,yPos=50,tamanho=10 -> all four flags 1; write while busy -> no effect.

Source files
------------

// File: rtl/colide_pkg.sv
// ============================================================================
// Module      : colide_pkg
// Description : Shared types and constants for the colide_scan collision
//               engine: obstacle record, FSM state encoding, default maze
//               table and small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package colide_pkg;

    // Coordinate widths of the stored obstacle records (VGA 640x480 space)
    localparam int OBST_X_W       = 10;
    localparam int OBST_Y_W       = 9;
    localparam int OBST_N_DEFAULT = 10;

    typedef struct packed {
        logic [OBST_X_W-1:0] ini_x;
        logic [OBST_X_W-1:0] fin_x;
        logic [OBST_Y_W-1:0] ini_y;
        logic [OBST_Y_W-1:0] fin_y;
    } obstacle_t;

    // Scan FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Maze walls of the moving-object demo
    localparam obstacle_t OBST_DEFAULT [OBST_N_DEFAULT] = '{
        '{10'd105, 10'd350, 9'd100, 9'd110},
        '{10'd345, 10'd350, 9'd100, 9'd280},
        '{10'd105, 10'd280, 9'd170, 9'd180},
        '{10'd275, 10'd280, 9'd170, 9'd350},
        '{10'd345, 10'd590, 9'd270, 9'd280},
        '{10'd275, 10'd510, 9'd340, 9'd350},
        '{10'd585, 10'd590, 9'd270, 9'd450},
        '{10'd505, 10'd510, 9'd340, 9'd390},
        '{10'd105, 10'd590, 9'd440, 9'd450},
        '{10'd105, 10'd510, 9'd380, 9'd390}
    };

    // Default record for table slot i; slots beyond the maze are empty
    // (a zero-size rectangle can never produce a strict overlap).
    function automatic obstacle_t obst_default(input int i);
        obstacle_t r;
        r = '0;
        if (i >= 0 && i < OBST_N_DEFAULT) begin
            r = OBST_DEFAULT[i[3:0]];
        end
        return r;
    endfunction

    // Index width, never below one bit so N_OBST=1 still has a counter
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/colide_obst_cmp.sv
// ============================================================================
// Module      : colide_obst_cmp
// Description : Combinational test of one square box against one obstacle
//               rectangle. Produces the four direction flags. Purely
//               combinational; the scanner time-multiplexes one instance.
// Ports       : xpos_i/ypos_i/size_i  box left, top, side length
//               obst_i                obstacle rectangle (ini/fin x/y)
//               min_x_o..max_y_o      direction collision flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module colide_obst_cmp
    import colide_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int T_W = 7
) (
    input  logic [X_W-1:0] xpos_i,
    input  logic [Y_W-1:0] ypos_i,
    input  logic [T_W-1:0] size_i,
    input  obstacle_t      obst_i,
    output logic           min_x_o,
    output logic           max_x_o,
    output logic           min_y_o,
    output logic           max_y_o
);

    // Everything is compared one bit wider than the coordinates so the
    // far edge (pos + size) never wraps around.
    logic [X_W:0] w_x0, w_x1, w_ix, w_fx;
    logic [Y_W:0] w_y0, w_y1, w_iy, w_fy;
    logic         w_xov, w_yov;

    assign w_x0 = (X_W+1)'(xpos_i);
    assign w_y0 = (Y_W+1)'(ypos_i);
    assign w_x1 = w_x0 + (X_W+1)'(size_i);
    assign w_y1 = w_y0 + (Y_W+1)'(size_i);
    assign w_ix = (X_W+1)'(obst_i.ini_x);
    assign w_fx = (X_W+1)'(obst_i.fin_x);
    assign w_iy = (Y_W+1)'(obst_i.ini_y);
    assign w_fy = (Y_W+1)'(obst_i.fin_y);

    // Strict comparisons: sharing an edge is not an overlap
    assign w_xov = (w_x1 > w_ix) && (w_x0 < w_fx);
    assign w_yov = (w_y1 > w_iy) && (w_y0 < w_fy);

    assign min_x_o = (w_x0 > w_ix) && (w_x0 < w_fx) && w_yov;
    assign max_x_o = (w_x1 > w_ix) && (w_x1 < w_fx) && w_yov;
    assign min_y_o = (w_y0 > w_iy) && (w_y0 < w_fy) && w_xov;
    assign max_y_o = (w_y1 > w_iy) && (w_y1 < w_fy) && w_xov;

endmodule

`default_nettype wire

// File: rtl/colide_scan.sv
// ============================================================================
// Module      : colide_scan
// Description : Box-vs-obstacle collision engine. On start, latches the box
//               and scans N_OBST obstacles one per clock, OR-accumulating
//               the four direction flags, then presents them with a
//               one-cycle valid pulse. Flags hold until the next result.
// Ports       : VGA_clk, reset (sync, active-high)
//               start, xPos, yPos, tamanho           request
//               busy, valid, colisao_{min,max}_{x,y} status / result
//               obst_we, obst_addr, obst_data        table write (macro only)
// Config      : COLIDE_OBST_WR_EN - obstacle table becomes a writable
//               register array, reset-loaded from the package defaults.
//               Without it the table is the constant package maze.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module colide_scan
    import colide_pkg::*;
#(
    parameter int N_OBST = 10,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int T_W    = 7
) (
    input  logic                      VGA_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [X_W-1:0]            xPos,
    input  logic [Y_W-1:0]            yPos,
    input  logic [T_W-1:0]            tamanho,
`ifdef COLIDE_OBST_WR_EN
    input  logic                      obst_we,
    input  logic [idx_w(N_OBST)-1:0]  obst_addr,
    input  obstacle_t                 obst_data,
`endif
    output logic                      busy,
    output logic                      valid,
    output logic                      colisao_min_x,
    output logic                      colisao_max_x,
    output logic                      colisao_min_y,
    output logic                      colisao_max_y
);

    localparam int IDX_W = idx_w(N_OBST);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [T_W-1:0]   t_q, t_d;
    // flag vectors ordered {min_x, max_x, min_y, max_y}
    logic [3:0]       acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;

    obstacle_t        w_obst;
    logic [3:0]       w_hit;
    logic             w_last;

    assign w_last = (idx_q == IDX_W'(N_OBST - 1));

    // ------------------------------------------------------------------
    // Obstacle table
    // ------------------------------------------------------------------
`ifdef COLIDE_OBST_WR_EN
    obstacle_t tab_q [N_OBST];
    logic      w_wr_ok;

    // A start in the same cycle takes priority; the write is dropped.
    assign w_wr_ok = obst_we && (state_q == S_IDLE) && !start
                     && (int'(obst_addr) < N_OBST);

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            for (int i = 0; i < N_OBST; i++) begin
                tab_q[i] <= obst_default(i);
            end
        end else if (w_wr_ok) begin
            tab_q[obst_addr] <= obst_data;
        end
    end

    assign w_obst = tab_q[idx_q];
`else
    obstacle_t w_tab [N_OBST];

    for (genvar g = 0; g < N_OBST; g++) begin : g_tab
        assign w_tab[g] = obst_default(g);
    end

    assign w_obst = w_tab[idx_q];
`endif

    // ------------------------------------------------------------------
    // Single comparator, fed with the obstacle selected by idx_q
    // ------------------------------------------------------------------
    colide_obst_cmp #(
        .X_W (X_W),
        .Y_W (Y_W),
        .T_W (T_W)
    ) u_cmp (
        .xpos_i  (x_q),
        .ypos_i  (y_q),
        .size_i  (t_q),
        .obst_i  (w_obst),
        .min_x_o (w_hit[3]),
        .max_x_o (w_hit[2]),
        .min_y_o (w_hit[1]),
        .max_y_o (w_hit[0])
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_SCAN;
            S_SCAN:  if (w_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy  = (state_q != S_IDLE);
        valid = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: latch request, advance index, accumulate flags
    // ------------------------------------------------------------------
    always_comb begin
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        t_d     = t_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d   = xPos;
                    y_d   = yPos;
                    t_d   = tamanho;
                    idx_d = '0;
                    acc_d = '0;
                end
            end
            S_SCAN: begin
                acc_d = acc_q | w_hit;
                idx_d = w_last ? '0 : idx_q + IDX_W'(1);
                // Result register is loaded on the last obstacle so it is
                // already visible while valid is high in DONE.
                if (w_last) begin
                    flags_d = acc_q | w_hit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    assign colisao_min_x = flags_q[3];
    assign colisao_max_x = flags_q[2];
    assign colisao_min_y = flags_q[1];
    assign colisao_max_y = flags_q[0];

endmodule

`default_nettype wire
